dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the RISC-V core. It takes the MemRead/MemWrite requests that the control path issues and runs them against the external data memory's cen/wen/stall interface. It stalls the core until each access completes, then returns load data. It sits between the core's load/store datapath and the data memory, and adds a timeout and an illegal-request check.

## Interface
- ADDR_W, 32, byte-address width
- DATA_W, 32, data word width
- TIMEOUT, 255, maximum WAIT cycles before an access is aborted (≥1)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- core_mem_read  in  1  load request (level, held by core while stalled)
- core_mem_write  in  1  store request (level, held by core while stalled)
- core_addr  in  ADDR_W  byte address
- core_wdata  in  DATA_W  store data
- core_rdata  out  DATA_W  load data, registered
- core_stall  out  1  core must hold PC and request
- core_err  out  1  one-cycle error pulse (illegal request or timeout)
- mem_cen  out  1  memory access strobe
- mem_wen  out  1  1 = write, qualified by mem_cen
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered store data
- mem_rdata  in  DATA_W  memory read data
- mem_stall  in  1  memory busy

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- IDLE, no request: stay in IDLE.
- IDLE, legal request: exactly one of read or write is asserted, and core_addr[1:0]==0.
  - Latch addr, wdata and the read/write type.
  - Go to REQ.
- IDLE, illegal request: both read and write asserted, or the address is misaligned.
  - No memory access.
  - core_err=1 next cycle for one cycle.
  - core_stall=0.
  - Stay in IDLE.
- REQ: mem_cen=1 and mem_wen=type for this single cycle. Next state is WAIT and the timeout counter clears to 0.
- WAIT: mem_cen=0.
  - mem_stall==0: completion. For a read, core_rdata is loaded from mem_rdata at this edge. Go to DONE.
  - Otherwise the counter increments.
  - Counter == TIMEOUT-1 while still stalled: abort to DONE with the error flag set. For a read, core_rdata is loaded with 0.
- DONE: one cycle. core_stall=0, core_err=error flag. Next state is IDLE unconditionally, so the core advances at the end of DONE.
- core_stall (combinational) = (IDLE & legal request) | REQ | WAIT. It is forced to 0 while rst_n is low.
- core_rdata holds its value until the next read completes or aborts. Writes never change it.
- mem_addr and mem_wdata hold their last values between accesses.
- Counter width is $clog2(TIMEOUT+1). The counter saturates and never wraps.

## Timing
- Reset values: core_rdata=0, core_err=0, core_stall=0, mem_cen=0, mem_wen=0, mem_addr=0, mem_wdata=0, state IDLE, counter 0.
- Assertion of rst_n low in any state returns to IDLE immediately. mem_cen drops asynchronously and the in-flight access is abandoned.
- Minimum latency: request seen in cycle 0 (IDLE), REQ in cycle 1, WAIT in cycle 2 with mem_stall=0, DONE in cycle 3.
  - core_stall is high for cycles 0–2.
  - core_rdata is valid from cycle 3.
- Each extra mem_stall cycle in WAIT adds one stall cycle.
- Timeout: WAIT lasts TIMEOUT cycles, then DONE with core_err=1.
- mem_stall is ignored outside WAIT.
- Request inputs are ignored in REQ, WAIT and DONE. The core is expected to hold them stable.
- Back-to-back accesses: a new request in the cycle after DONE starts a fresh transaction. Minimum spacing is 4 cycles per access.

## Test plan
- Load, mem_stall=0, addr=0x100, mem_rdata=0xDEADBEEF:
  - mem_cen pulses in cycle 1 with wen=0 and mem_addr=0x100.
  - core_stall is high for cycles 0–2.
  - core_rdata=0xDEADBEEF from cycle 3, core_err=0.
- Store, addr=0x40, wdata=0x12345678, mem_stall high for 5 WAIT cycles:
  - mem_cen and mem_wen are high for one cycle with the latched address and data.
  - core_stall lasts 8 cycles.
  - core_rdata is unchanged.
- Read with mem_stall stuck high, TIMEOUT=4:
  - DONE is reached after 4 WAIT cycles.
  - core_err pulses for 1 cycle and core_rdata=0.
- Illegal requests: read and write both at 1, then a load at addr=0x102.
  - No mem_cen and no stall for either.
  - core_err pulses one cycle after each.
- rst_n pulled low during WAIT:
  - All outputs go to 0 immediately and the state returns to IDLE.
  - After release, a load completes normally with 4-cycle minimum latency.
- Two back-to-back loads (0x0, then 0x4 presented the cycle after DONE):
  - Two separate mem_cen pulses 4 cycles apart.
  - core_rdata updates once per access.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Bundle of the core-side load/store request signals and the data-memory cen/wen/stall port.
// master = core + memory environment, slave = the responder.
interface dmem_responder_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              core_mem_read;
  logic              core_mem_write;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_stall;
  logic              core_err;
  logic              mem_cen;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_stall;

  modport master (
    output core_mem_read, core_mem_write, core_addr, core_wdata, mem_rdata, mem_stall,
    input  core_rdata, core_stall, core_err, mem_cen, mem_wen, mem_addr, mem_wdata
  );

  modport slave (
    input  core_mem_read, core_mem_write, core_addr, core_wdata, mem_rdata, mem_stall,
    output core_rdata, core_stall, core_err, mem_cen, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_responder.sv
// Runs core load/store requests against the data memory, stalling the core until each access
// completes, with a WAIT timeout and an illegal-request (both ops / misaligned) check.
module dmem_responder #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic            clk,
  input logic            rst_n,
  dmem_responder_if.slave bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              is_write_q, is_write_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic req_any, req_legal;

  assign req_any   = bus.core_mem_read | bus.core_mem_write;
  assign req_legal = (bus.core_mem_read ^ bus.core_mem_write) && (bus.core_addr[1:0] == 2'b00);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_legal) begin
          addr_d     = bus.core_addr;
          wdata_d    = bus.core_wdata;
          is_write_d = bus.core_mem_write;
          state_d    = StReq;
        end else if (req_any) begin
          err_d = 1'b1;
        end
      end
      StReq: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (!bus.mem_stall) begin
          if (!is_write_q) rdata_d = bus.mem_rdata;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          // Aborted loads return zero so the core never consumes stale data.
          err_d = 1'b1;
          if (!is_write_q) rdata_d = '0;
          state_d = StDone;
        end else if (cnt_q != {CntW{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      is_write_q <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Stall is gated by rst_n so it drops immediately on asynchronous reset.
  assign bus.core_stall = rst_n & (((state_q == StIdle) & req_legal) |
                                   (state_q == StReq) | (state_q == StWait));
  assign bus.core_err   = err_q;
  assign bus.core_rdata = rdata_q;
  assign bus.mem_cen    = (state_q == StReq);
  assign bus.mem_wen    = (state_q == StReq) & is_write_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random transactions checked
// cycle by cycle against a transaction-level model of stall length, strobes, error and load data.
module tb_dmem_responder;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_responder #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state: what the core/memory should observe between accesses.
  logic [DW-1:0] m_rdata;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_pend_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.core_mem_read  = 1'b0;
    bus.core_mem_write = 1'b0;
    bus.core_addr      = $urandom;
    bus.core_wdata     = $urandom;
    bus.mem_stall      = 1'($urandom_range(0, 1));
    bus.mem_rdata      = $urandom;
  endtask

  // One request as the core presents it; nstall = stalled WAIT cycles the memory inserts.
  task automatic do_access(input logic rd, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [DW-1:0] rdv, input int nstall);
    logic          legal;
    logic          abort;
    int            waits;
    int            total;
    logic [DW-1:0] new_rd;
    legal = (rd ^ wr) && (a[1:0] == 2'b00);
    if (!legal) begin
      @(negedge clk);
      drive_idle();
      bus.core_mem_read  = rd;
      bus.core_mem_write = wr;
      bus.core_addr      = a;
      bus.core_wdata     = wd;
      #1;
      chk("idle_stall", bus.core_stall, 1'b0);
      chk("idle_cen", bus.mem_cen, 1'b0);
      chk("idle_err", bus.core_err, m_pend_err);
      chk("idle_rdata", bus.core_rdata, m_rdata);
      chk("idle_addr_hold", bus.mem_addr, m_addr);
      chk("idle_wdata_hold", bus.mem_wdata, m_wdata);
      m_pend_err = rd | wr;
      return;
    end
    abort  = (nstall >= int'(TO));
    waits  = abort ? int'(TO) : nstall + 1;
    total  = 3 + waits;
    new_rd = wr ? m_rdata : (abort ? '0 : rdv);
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      bus.core_mem_read  = rd;
      bus.core_mem_write = wr;
      bus.core_addr      = a;
      bus.core_wdata     = wd;
      bus.mem_stall      = (c >= 2) ? ((c - 2) < nstall) : 1'($urandom_range(0, 1));
      bus.mem_rdata      = (c == 2 + nstall) ? rdv : $urandom;
      #1;
      chk("stall", bus.core_stall, (c < 2 + waits));
      chk("cen", bus.mem_cen, (c == 1));
      chk("err", bus.core_err, (c == 0) ? m_pend_err : ((c == total - 1) && abort));
      chk("rdata", bus.core_rdata, (c == total - 1) ? new_rd : m_rdata);
      if (c == 1) begin
        chk("wen", bus.mem_wen, wr);
        chk("mem_addr", bus.mem_addr, a);
        chk("mem_wdata", bus.mem_wdata, wd);
      end
    end
    m_rdata    = new_rd;
    m_addr     = a;
    m_wdata    = wd;
    m_pend_err = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"}, bus.core_stall, 1'b0);
    chk({tag, "_cen"}, bus.mem_cen, 1'b0);
    chk({tag, "_wen"}, bus.mem_wen, 1'b0);
    chk({tag, "_err"}, bus.core_err, 1'b0);
    chk({tag, "_rdata"}, bus.core_rdata, '0);
    chk({tag, "_addr"}, bus.mem_addr, '0);
    chk({tag, "_wdata"}, bus.mem_wdata, '0);
  endtask

  task automatic reset_in_wait();
    @(negedge clk);
    drive_idle();
    bus.core_mem_read = 1'b1;
    bus.core_addr     = 32'h200;
    bus.core_wdata    = 32'hCAFE0001;
    bus.mem_stall     = 1'b1;
    #1 chk("rst_pre_stall", bus.core_stall, 1'b1);
    @(negedge clk);
    #1 chk("rst_pre_cen", bus.mem_cen, 1'b1);
    @(negedge clk);
    #1 chk("rst_wait_stall", bus.core_stall, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_async");
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    m_rdata    = '0;
    m_addr     = '0;
    m_wdata    = '0;
    m_pend_err = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] a;
    logic          rd;
    logic          wr;
    int            kind;
    int            ns;

    drive_idle();
    // A legal request during reset must not raise stall.
    bus.core_mem_read = 1'b1;
    bus.core_addr     = 32'h100;
    rst_n             = 1'b0;
    #1 check_all_zero("reset");
    m_rdata    = '0;
    m_addr     = '0;
    m_wdata    = '0;
    m_pend_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;

    do_access(1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    do_access(1'b0, 1'b1, 32'h40, 32'h12345678, $urandom, 5);
    do_access(1'b1, 1'b0, 32'h80, $urandom, $urandom, 100);
    do_access(1'b1, 1'b0, 32'h84, $urandom, 32'hA5A55A5A, 2);
    do_access(1'b0, 1'b1, 32'h88, 32'h0BADF00D, $urandom, TO);
    do_access(1'b1, 1'b0, 32'h8C, $urandom, 32'h13579BDF, TO - 1);
    do_access(1'b1, 1'b1, 32'h10, $urandom, $urandom, 0);
    do_access(1'b0, 1'b0, $urandom, $urandom, $urandom, 0);
    do_access(1'b1, 1'b0, 32'h102, $urandom, $urandom, 0);
    do_access(1'b0, 1'b0, $urandom, $urandom, $urandom, 0);
    reset_in_wait();
    do_access(1'b1, 1'b0, 32'h0, $urandom, 32'h11112222, 0);
    do_access(1'b1, 1'b0, 32'h4, $urandom, 32'h33334444, 0);

    for (int i = 0; i < 200; i++) begin
      kind = int'($urandom_range(0, 9));
      a    = $urandom;
      a[1:0] = 2'b00;
      rd   = (kind <= 3) || (kind == 7) || (kind == 8);
      wr   = (kind >= 4) && (kind <= 7);
      if (kind == 8) a[1:0] = 2'($urandom_range(1, 3));
      if (kind == 9) begin
        rd = 1'b0;
        wr = 1'b0;
      end
      case ($urandom_range(0, 5))
        0:       ns = int'(TO) - 1;
        1:       ns = int'(TO) + int'($urandom_range(0, 3));
        default: ns = int'($urandom_range(0, 3));
      endcase
      do_access(rd, wr, a, $urandom, $urandom, ns);
    end
    do_access(1'b0, 1'b0, $urandom, $urandom, $urandom, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
